// File: rtl/ex_mdu_pkg.sv
// ex_mdu_pkg: shared definitions for the multiply/divide unit.
//   - default parameter values (XLEN, MUL_LAT, TAG_W)
//   - operation codes (mdu_op_e) and FSM state encoding (mdu_state_e)
//   - small op-classification helpers
package ex_mdu_pkg;

  localparam int unsigned XLEN_DEF    = 32;
  localparam int unsigned MUL_LAT_DEF = 2;
  localparam int unsigned TAG_W_DEF   = 5;

  typedef enum logic [2:0] {
    OP_MUL   = 3'd0,
    OP_MULH  = 3'd1,
    OP_MULHU = 3'd2,
    OP_DIV   = 3'd3,
    OP_MOD   = 3'd4,
    OP_DIVU  = 3'd5,
    OP_MODU  = 3'd6,
    OP_RSVD  = 3'd7
  } mdu_op_e;

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_MUL  = 2'd1,
    S_DIV  = 2'd2,
    S_DONE = 2'd3
  } mdu_state_e;

  function automatic logic op_is_mul(input mdu_op_e op);
    return op inside {OP_MUL, OP_MULH, OP_MULHU};
  endfunction

  function automatic logic op_is_sdiv(input mdu_op_e op);
    return op inside {OP_DIV, OP_MOD};
  endfunction

  function automatic logic op_is_rem(input mdu_op_e op);
    return op inside {OP_MOD, OP_MODU};
  endfunction

endpackage

// File: rtl/ex_mdu_divcore.sv
// ex_mdu_divcore: iterative restoring divider on unsigned magnitudes.
//   clk, rst     : clock, synchronous active-high reset
//   i_start      : load operands and begin (one quotient bit per cycle)
//   i_abort      : drop the operation and clear the iteration counter
//   i_dividend   : unsigned dividend magnitude
//   i_divisor    : unsigned divisor magnitude (non-zero)
//   o_done       : one-cycle pulse, o_quotient/o_remainder valid with it
module ex_mdu_divcore
  import ex_mdu_pkg::*;
#(
  parameter int unsigned XLEN = XLEN_DEF
) (
  input  logic            clk,
  input  logic            rst,
  input  logic            i_start,
  input  logic            i_abort,
  input  logic [XLEN-1:0] i_dividend,
  input  logic [XLEN-1:0] i_divisor,
  output logic            o_done,
  output logic [XLEN-1:0] o_quotient,
  output logic [XLEN-1:0] o_remainder
);

  localparam int unsigned CW = $clog2(XLEN);

  logic [CW-1:0]   r_cnt;
  logic            r_busy;
  logic            r_done;
  logic [XLEN-1:0] r_rem;
  logic [XLEN-1:0] r_quo;
  logic [XLEN-1:0] r_dvs;
  logic [XLEN:0]   w_trial;
  logic [XLEN:0]   w_diff;

  // Shift the next dividend bit into the partial remainder; a set MSB on
  // the difference means the trial subtraction must be undone.
  assign w_trial = {r_rem, r_quo[XLEN-1]};
  assign w_diff  = w_trial - {1'b0, r_dvs};

  always_ff @(posedge clk) begin
    if (rst || i_abort) begin
      r_busy <= 1'b0;
      r_done <= 1'b0;
      r_cnt  <= '0;
      r_rem  <= '0;
      r_quo  <= '0;
      r_dvs  <= '0;
    end else begin
      r_done <= 1'b0;
      if (i_start) begin
        r_busy <= 1'b1;
        r_cnt  <= '0;
        r_rem  <= '0;
        r_quo  <= i_dividend;
        r_dvs  <= i_divisor;
      end else if (r_busy) begin
        if (w_diff[XLEN]) begin
          r_rem <= w_trial[XLEN-1:0];
          r_quo <= {r_quo[XLEN-2:0], 1'b0};
        end else begin
          r_rem <= w_diff[XLEN-1:0];
          r_quo <= {r_quo[XLEN-2:0], 1'b1};
        end
        if (r_cnt == CW'(XLEN - 1)) begin
          r_busy <= 1'b0;
          r_done <= 1'b1;
          r_cnt  <= '0;
        end else begin
          r_cnt <= r_cnt + CW'(1);
        end
      end
    end
  end

  assign o_done      = r_done;
  assign o_quotient  = r_quo;
  assign o_remainder = r_rem;

endmodule

// File: rtl/ex_mdu.sv
// ex_mdu: single-issue integer multiply/divide unit with valid/ready ports.
//   clk, rst              : clock, synchronous active-high reset
//   flush                 : cancel any in-flight or held operation
//   in_valid/in_ready     : request handshake; in_op, in_src1, in_src2, in_tag
//   out_valid/out_ready   : result handshake; out_result, out_tag
//   busy                  : unit not idle
// Multiplies run through a MUL_LAT-stage register pipeline; divides use
// ex_mdu_divcore on magnitudes with sign fix here. Divide by zero, signed
// overflow and the reserved op complete one cycle after accept.
module ex_mdu
  import ex_mdu_pkg::*;
#(
  parameter int unsigned XLEN    = XLEN_DEF,
  parameter int unsigned MUL_LAT = MUL_LAT_DEF,
  parameter int unsigned TAG_W   = TAG_W_DEF
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             flush,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [2:0]       in_op,
  input  logic [XLEN-1:0]  in_src1,
  input  logic [XLEN-1:0]  in_src2,
  input  logic [TAG_W-1:0] in_tag,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [XLEN-1:0]  out_result,
  output logic [TAG_W-1:0] out_tag,
  output logic             busy
);

  localparam int unsigned   CW       = $clog2(MUL_LAT + 1);
  localparam logic [XLEN-1:0] MOST_NEG = {1'b1, {(XLEN-1){1'b0}}};

  mdu_state_e         r_state, w_next, w_acc_state;
  mdu_op_e            w_in_op, r_op;
  logic               w_accept, w_sdiv_in, w_dz, w_ovf, w_early_in;
  logic [XLEN-1:0]    w_early_res_in, w_mag1, w_mag2;
  logic [2*XLEN-1:0]  w_ma, w_mb, w_prod;
  logic               w_div_start, w_div_done, w_mul_last, w_div_fin, w_load;
  logic [XLEN-1:0]    w_quo, w_rem, w_res;
  logic [TAG_W-1:0]   r_tag, r_out_tag;
  logic [XLEN-1:0]    r_result, r_early_res;
  logic               r_early, r_neg_q, r_neg_r;
  logic [CW-1:0]      r_mcnt;
  logic [2*XLEN-1:0]  r_mp [MUL_LAT];

  assign in_ready  = (r_state == S_IDLE) | ((r_state == S_DONE) & out_ready);
  assign out_valid = (r_state == S_DONE);
  assign busy      = (r_state != S_IDLE);
  assign w_accept  = in_valid & in_ready & ~flush;

  assign w_in_op     = mdu_op_e'(in_op);
  assign w_acc_state = op_is_mul(w_in_op) ? S_MUL : S_DIV;
  assign w_sdiv_in   = op_is_sdiv(w_in_op);
  assign w_mag1      = (w_sdiv_in & in_src1[XLEN-1]) ? -in_src1 : in_src1;
  assign w_mag2      = (w_sdiv_in & in_src2[XLEN-1]) ? -in_src2 : in_src2;
  assign w_dz        = (in_src2 == '0);
  assign w_ovf       = w_sdiv_in & (in_src1 == MOST_NEG) & (in_src2 == '1);
  assign w_early_in  = (w_in_op == OP_RSVD) | (~op_is_mul(w_in_op) & (w_dz | w_ovf));
  assign w_div_start = w_accept & ~op_is_mul(w_in_op) & ~w_early_in;

  always_comb begin
    w_early_res_in = '0;
    if (w_in_op == OP_RSVD)
      w_early_res_in = '0;
    else if (w_dz)
      w_early_res_in = op_is_rem(w_in_op) ? in_src1 : '1;
    else if (w_ovf)
      w_early_res_in = op_is_rem(w_in_op) ? '0 : MOST_NEG;
  end

  // Sign- or zero-extend to 2*XLEN; the truncated product is then the
  // exact signed (or unsigned) product.
  assign w_ma   = (w_in_op == OP_MULHU) ? {{XLEN{1'b0}}, in_src1}
                                        : {{XLEN{in_src1[XLEN-1]}}, in_src1};
  assign w_mb   = (w_in_op == OP_MULHU) ? {{XLEN{1'b0}}, in_src2}
                                        : {{XLEN{in_src2[XLEN-1]}}, in_src2};
  assign w_prod = w_ma * w_mb;

  ex_mdu_divcore #(.XLEN(XLEN)) u_divcore (
    .clk         (clk),
    .rst         (rst),
    .i_start     (w_div_start),
    .i_abort     (flush),
    .i_dividend  (w_mag1),
    .i_divisor   (w_mag2),
    .o_done      (w_div_done),
    .o_quotient  (w_quo),
    .o_remainder (w_rem)
  );

  assign w_mul_last = (r_state == S_MUL) && (r_mcnt == CW'(MUL_LAT - 1));
  assign w_div_fin  = (r_state == S_DIV) && (r_early || w_div_done);
  assign w_load     = ~flush & (w_mul_last | w_div_fin);

  always_comb begin
    w_res = r_result;
    if (r_state == S_MUL)
      w_res = (r_op == OP_MUL) ? r_mp[MUL_LAT-1][XLEN-1:0]
                               : r_mp[MUL_LAT-1][2*XLEN-1:XLEN];
    else if (r_early)
      w_res = r_early_res;
    else if (op_is_rem(r_op))
      w_res = r_neg_r ? -w_rem : w_rem;
    else
      w_res = r_neg_q ? -w_quo : w_quo;
  end

  always_comb begin
    w_next = r_state;
    unique case (r_state)
      S_IDLE:  if (w_accept) w_next = w_acc_state;
      S_MUL:   if (w_mul_last) w_next = S_DONE;
      S_DIV:   if (w_div_fin) w_next = S_DONE;
      S_DONE:  if (out_ready) w_next = w_accept ? w_acc_state : S_IDLE;
      default: w_next = S_IDLE;
    endcase
    if (flush) w_next = S_IDLE;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      r_state     <= S_IDLE;
      r_op        <= OP_MUL;
      r_tag       <= '0;
      r_out_tag   <= '0;
      r_result    <= '0;
      r_early     <= 1'b0;
      r_early_res <= '0;
      r_neg_q     <= 1'b0;
      r_neg_r     <= 1'b0;
      r_mcnt      <= '0;
      for (int unsigned i = 0; i < MUL_LAT; i++) r_mp[i] <= '0;
    end else begin
      r_state <= w_next;
      if (w_accept) begin
        r_op        <= w_in_op;
        r_tag       <= in_tag;
        r_early     <= w_early_in;
        r_early_res <= w_early_res_in;
        r_neg_q     <= w_sdiv_in & (in_src1[XLEN-1] ^ in_src2[XLEN-1]);
        r_neg_r     <= w_sdiv_in & in_src1[XLEN-1];
        r_mcnt      <= '0;
        r_mp[0]     <= w_prod;
      end else if (r_state == S_MUL) begin
        r_mcnt <= r_mcnt + CW'(1);
      end
      for (int unsigned i = 1; i < MUL_LAT; i++) r_mp[i] <= r_mp[i-1];
      if (w_load) begin
        r_result  <= w_res;
        r_out_tag <= r_tag;
      end
    end
  end

  assign out_result = r_result;
  assign out_tag    = r_out_tag;

endmodule

// File: doc/ex_mdu.md
EX_MDU -- requirements
Module: ex_mdu

Interface
REQ-001 Parameter XLEN, default 32, operand and result width in bits (even, >= 8).
REQ-002 Parameter MUL_LAT, default 2, multiply latency in cycles from accept to out_valid (>= 1).
REQ-003 Parameter TAG_W, default 5, width of the opaque tag carried with each operation.
REQ-004 clk  input  1  clock; all state updates on the rising edge.
REQ-005 rst  input  1  reset, synchronous, active-high.
REQ-006 flush  input  1  cancels any in-flight or held operation.
REQ-007 in_valid  input  1  request present.
REQ-008 in_ready  output  1  unit can accept a request this cycle.
REQ-009 in_op  input  3  operation code: MUL=0, MULH=1, MULHU=2, DIV=3, MOD=4, DIVU=5, MODU=6, 7 reserved.
REQ-010 in_src1, in_src2  input  XLEN  dividend/multiplicand and divisor/multiplier.
REQ-011 in_tag  input  TAG_W  tag returned unchanged with the result.
REQ-012 out_valid  output  1  result present.
REQ-013 out_ready  input  1  consumer takes the result this cycle.
REQ-014 out_result  output  XLEN  result; out_tag  output  TAG_W  tag of that result.
REQ-015 busy  output  1  high in any state other than IDLE.

Function
REQ-016 States: IDLE, MUL, DIV, DONE; accept = in_valid & in_ready & ~flush.
REQ-017 in_ready = (state==IDLE) | (state==DONE & out_ready), giving back-to-back issue with no bubble.
REQ-018 On accept, operands, op and tag are captured; in_src1/in_src2 are not sampled afterwards.
REQ-019 MUL/MULH/MULHU: the 2*XLEN product is signed x signed for MUL and MULH, and unsigned x unsigned for MULHU.
REQ-020 MUL returns product[XLEN-1:0]; MULH and MULHU return product[2XLEN-1:XLEN]; out_valid rises exactly MUL_LAT cycles after the accept edge.
REQ-021 DIV/MOD are signed, truncating toward zero; the remainder takes the sign of the dividend; DIVU/MODU are unsigned.
REQ-022 Normal divide: restoring, one quotient bit per cycle on magnitudes, then one sign-fix cycle; out_valid rises XLEN+1 cycles after accept.
REQ-023 Early out, divisor==0: quotient = all ones, remainder = dividend; out_valid rises 1 cycle after accept.
REQ-024 Early out, signed overflow (dividend = most-negative, divisor = -1): quotient = most-negative, remainder = 0; out_valid rises 1 cycle after accept.
REQ-025 Reserved op 7: result 0; out_valid rises 1 cycle after accept.
REQ-026 DONE holds out_valid, out_result and out_tag stable until out_ready; they are stable for any number of stall cycles.
REQ-027 DONE & out_ready & ~accept -> IDLE; DONE & out_ready & accept -> MUL or DIV on the same edge.
REQ-028 flush in any state: next state is IDLE, out_valid is 0 the next cycle, and the divider iteration counter clears; flush beats accept and out_ready in the same cycle.
REQ-029 A result is never emitted for an operation accepted before a flush.
REQ-030 out_result and out_tag are don't-care while out_valid = 0, but are not X after reset.

Reset
REQ-031 On rst: state = IDLE, out_valid = 0, busy = 0, in_ready = 1, out_result = 0, out_tag = 0, iteration counter = 0.
REQ-032 rst overrides flush, accept and out_ready, and aborts any operation mid-divide or mid-multiply without emitting a result.

Structure
REQ-033 Package ex_mdu_pkg holds the op-code constants, the state encoding and the default parameter values.
REQ-034 Sub-module ex_mdu_divcore holds the iterative restoring divider (start, abort, done, unsigned magnitudes in, quotient/remainder out).
REQ-035 Signed pre-negation, early-out detection and sign fix stay in ex_mdu.
REQ-036 The multiplier is a MUL_LAT-stage pipeline of registers inside ex_mdu; only one operation is in flight at a time.

Verification
REQ-037 XLEN=32: DIV -7 / 2 -> out_result 0xFFFFFFFD; MOD -> 0xFFFFFFFF; out_valid rises 33 cycles after accept.
REQ-038 DIVU 0x12345678 / 0 -> 0xFFFFFFFF; MODU -> 0x12345678; out_valid rises 1 cycle after accept.
REQ-039 DIV 0x80000000 / 0xFFFFFFFF -> 0x80000000; MOD -> 0; MULHU 0xFFFFFFFF x 0xFFFFFFFF -> 0xFFFFFFFE; MULH of the same operands -> 0.
REQ-040 out_ready held low for 10 cycles after a MUL of 3 x 5 with tag 9: out_result = 15 and out_tag = 9 are stable throughout and in_ready stays 0.
REQ-041 flush 10 cycles into a DIV: out_valid stays 0, in_ready = 1 the next cycle, and a new MUL 2 x 3 returns 6 after MUL_LAT cycles.
REQ-042 Back-to-back: a second request is accepted in the same cycle as the first result's out_ready handshake, and both tags are returned in order.
